// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: emits round keys 10 down to 0, one per rk handshake.
// Optional INV_KS_PRECOMP_EN: key_in is the cipher key and a forward pass derives round 10 first.
module aes_inv_key_sched #(
   parameter int unsigned KEY_LEN       = 128,
   parameter int unsigned NUMS_OF_ROUND = 10,
   parameter int unsigned WORD_LEN      = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [KEY_LEN-1:0] key_in,
   input  logic               valid_in,
   output logic               ready_out,
   output logic [KEY_LEN-1:0] rk_out,
   output logic [3:0]         rk_round,
   output logic               rk_valid,
   input  logic               rk_ready,
   output logic               done
);

   localparam int unsigned RND_W = 4;

`ifdef INV_KS_PRECOMP_EN
   typedef enum logic [1:0] {IDLE, EMIT, PRECOMP} state_t;
`else
   typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

   state_t               state_q, state_d;
   logic [KEY_LEN-1:0]   key_d;
   logic [RND_W-1:0]     round_d;
   logic                 valid_d, done_d, ready_d;
   logic [WORD_LEN-1:0]  w0, w1, w2, w3, p0, p1, p2, p3;
   logic [KEY_LEN-1:0]   prev_key;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse (x^254) followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = x;
      for (int i = 0; i < 6; i++) inv = gf_mul(gf_mul(inv, inv), x);
      inv = gf_mul(inv, inv);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [WORD_LEN-1:0] sub_rot(input logic [WORD_LEN-1:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [WORD_LEN-1:0] rcon(input logic [RND_W-1:0] r);
      logic [7:0] c;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return {c, 24'h000000};
   endfunction

   // Undo one forward round: recover the round r-1 key from the round r key.
   assign {w0, w1, w2, w3} = rk_out;
   assign p3       = w3 ^ w2;
   assign p2       = w2 ^ w1;
   assign p1       = w1 ^ w0;
   assign p0       = w0 ^ sub_rot(p3) ^ rcon(rk_round);
   assign prev_key = {p0, p1, p2, p3};

`ifdef INV_KS_PRECOMP_EN
   logic [RND_W-1:0]    cnt_q, cnt_d;
   logic [WORD_LEN-1:0] f0, f1, f2, f3;
   logic [KEY_LEN-1:0]  fwd_key;

   // Forward round cnt_q: derive the next round key from the current one.
   assign f0      = w0 ^ sub_rot(w3) ^ rcon(cnt_q);
   assign f1      = w1 ^ f0;
   assign f2      = w2 ^ f1;
   assign f3      = w3 ^ f2;
   assign fwd_key = {f0, f1, f2, f3};
`endif

   always_comb begin
      state_d = state_q;
      key_d   = rk_out;
      round_d = rk_round;
      valid_d = rk_valid;
      done_d  = 1'b0;
`ifdef INV_KS_PRECOMP_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (valid_in && ready_out) begin
               key_d = key_in;
`ifdef INV_KS_PRECOMP_EN
               cnt_d   = RND_W'(1);
               state_d = PRECOMP;
`else
               round_d = RND_W'(NUMS_OF_ROUND);
               valid_d = 1'b1;
               state_d = EMIT;
`endif
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (rk_round != '0) begin
                  key_d   = prev_key;
                  round_d = rk_round - RND_W'(1);
               end else begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
`ifdef INV_KS_PRECOMP_EN
         PRECOMP: begin
            key_d = fwd_key;
            if (cnt_q == RND_W'(NUMS_OF_ROUND)) begin
               round_d = RND_W'(NUMS_OF_ROUND);
               valid_d = 1'b1;
               state_d = EMIT;
            end else begin
               cnt_d = cnt_q + RND_W'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rk_out    <= '0;
         rk_round  <= '0;
         rk_valid  <= 1'b0;
         done      <= 1'b0;
         ready_out <= 1'b0;
`ifdef INV_KS_PRECOMP_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         rk_out    <= key_d;
         rk_round  <= round_d;
         rk_valid  <= valid_d;
         done      <= done_d;
         ready_out <= ready_d;
`ifdef INV_KS_PRECOMP_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: FIPS-197 round keys, backpressure, reset abort, busy/back-to-back.
module tb_aes_inv_key_sched;

   typedef struct packed {
      logic [3:0]   rnd;
      logic [127:0] key;
   } beat_t;

`ifdef INV_KS_PRECOMP_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 1;
`endif

   logic         clk      = 1'b0;
   logic         reset    = 1'b1;
   logic [127:0] key_in   = '0;
   logic         valid_in = 1'b0;
   logic         rk_ready = 1'b1;
   logic         ready_out, rk_valid, done;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;

   int    checks = 0;
   int    errors = 0;
   beat_t sb_q[$];
   logic  done_due   = 1'b0;
   logic  stall_pend = 1'b0;
   beat_t stall_val;
   logic  bp_mode    = 1'b0;
   int    stall_cnt  = 0;

   logic [127:0] model_rk [0:10];
   logic [127:0] fips_rk  [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
   logic [7:0] rcon_tb [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [0:255][7:0] sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   aes_inv_key_sched dut (
      .clk(clk), .reset(reset), .key_in(key_in), .valid_in(valid_in), .ready_out(ready_out),
      .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sub_rot_tb(input logic [31:0] w);
      return {sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]], sbox_tbl[w[31:24]]};
   endfunction

   // Textbook word-array expansion: forward from round 0, or backward from round 10.
   task automatic model_from(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
`ifdef INV_KS_PRECOMP_EN
      {w[0], w[1], w[2], w[3]} = k;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) t = sub_rot_tb(t) ^ {rcon_tb[i/4], 24'h000000};
         w[i] = w[i-4] ^ t;
      end
`else
      {w[40], w[41], w[42], w[43]} = k;
      for (int i = 43; i >= 4; i--) begin
         t = w[i-1];
         if (i % 4 == 0) t = sub_rot_tb(t) ^ {rcon_tb[i/4], 24'h000000};
         w[i-4] = w[i] ^ t;
      end
`endif
      for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic push_model();
      for (int r = 10; r >= 0; r--) sb_q.push_back(beat_t'({4'(r), model_rk[r]}));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [127:0] k, input logic hold, input logic [127:0] hold_k);
      int n;
      key_in   = k;
      valid_in = 1'b1;
      n = 0;
      while (!ready_out && n < 100) begin tick(); n++; end
      if (n >= 100) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout: ready_out never rose");
      end
      tick();
      valid_in = hold;
      key_in   = hold_k;
      n = 1;
      @(negedge clk);
      while (!rk_valid && n < 40) begin @(negedge clk); n++; end
      check("first_valid_latency", 132'(n), 132'(LAT));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 500) begin tick(); n++; end
      if (sb_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain_timeout: %0d beats still expected", sb_q.size());
      end
      repeat (3) tick();
   endtask

   // Backpressure driver: random rk_ready with a forced 5-cycle stall on round 5.
   always @(posedge clk) begin
      #1;
      if (!bp_mode) rk_ready = 1'b1;
      else if (rk_valid && rk_round == 4'd5 && stall_cnt < 5) begin
         rk_ready = 1'b0;
         stall_cnt++;
      end else rk_ready = ($urandom_range(0, 2) != 0);
   end

   // Monitor: pops the scoreboard on each handshake, checks stall stability and done timing.
   always @(negedge clk) begin
      beat_t e;
      if (reset) begin
         done_due   = 1'b0;
         stall_pend = 1'b0;
      end else begin
         if (done_due || done) check("done_pulse", 132'(done), 132'(done_due));
         done_due = 1'b0;
         if (stall_pend && rk_valid) check("stall_hold", 132'({rk_round, rk_out}), stall_val);
         stall_pend = rk_valid && !rk_ready;
         stall_val  = beat_t'({rk_round, rk_out});
         if (rk_valid && rk_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: round %0d key %h", rk_round, rk_out);
            end else begin
               e = sb_q.pop_front();
               check("beat", 132'({rk_round, rk_out}), e);
               if (e.rnd == 4'd0) done_due = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] key_a, key_b;
      int n, busy;
`ifdef INV_KS_PRECOMP_EN
      key_a = fips_rk[0];
`else
      key_a = fips_rk[10];
`endif
      key_b = 128'h000102030405060708090a0b0c0d0e0f;

      // Reset values
      repeat (3) tick();
      @(negedge clk);
      check("rst_ready", 132'(ready_out), 132'(0));
      check("rst_valid", 132'(rk_valid), 132'(0));
      check("rst_key", 132'(rk_out), 132'(0));
      check("rst_round", 132'(rk_round), 132'(0));
      check("rst_done", 132'(done), 132'(0));
      tick();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ready_after_reset", 132'(ready_out), 132'(1));

      // Bench model against the published FIPS-197 schedule
      model_from(key_a);
      for (int r = 0; r <= 10; r++) check("model_vs_fips", 132'(model_rk[r]), 132'(fips_rk[r]));

      // Basic sequence with key B held on valid_in, then accepted in the done cycle
      model_rk = fips_rk;
      push_model();
      model_from(key_b);
      push_model();
      send_key(key_a, 1'b1, key_b);
      busy = 0;
      n = 0;
      while (!done && n < 200) begin
         if (ready_out) busy++;
         @(negedge clk);
         n++;
      end
      check("busy_ready_cycles", 132'(busy), 132'(0));
      check("ready_in_done_cycle", 132'(ready_out), 132'(1));
      tick();
      valid_in = 1'b0;
      wait_drain();

      // Backpressure
      model_rk  = fips_rk;
      push_model();
      stall_cnt = 0;
      bp_mode   = 1'b1;
      send_key(key_a, 1'b0, '0);
      wait_drain();
      bp_mode = 1'b0;
      tick();

      // Reset after the round 6 handshake, then a fresh full run
      model_rk = fips_rk;
      push_model();
      send_key(key_a, 1'b0, '0);
      n = 0;
      while (!(rk_valid && rk_ready && rk_round == 4'd6) && n < 100) begin @(negedge clk); n++; end
      check("reached_round6", 132'(rk_round), 132'(6));
      tick();
      reset = 1'b1;
      sb_q.delete();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("abort_valid", 132'(rk_valid), 132'(0));
      check("abort_key", 132'(rk_out), 132'(0));
      check("abort_done", 132'(done), 132'(0));
      repeat (3) tick();
      check("abort_no_done", 132'(done), 132'(0));
      push_model();
      send_key(key_a, 1'b0, '0);
      wait_drain();

      // All-zero key
      model_from('0);
      push_model();
      send_key('0, 1'b0, '0);
      wait_drain();

      check("scoreboard_empty", 132'(sb_q.size()), 132'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
